// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding uart_tx: buffers host bytes and issues one data_en strobe per frame.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
  parameter int data_width_g = 8,
  parameter int depth_g      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_asy_n_i,
  input  logic                        rst_syn_i,
  input  logic [data_width_g-1:0]     wr_data_i,
  input  logic                        wr_en_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(depth_g):0]    level_o,
  output logic                        overflow_o,
  output logic [data_width_g-1:0]     tx_data_o,
  output logic                        tx_en_o,
  input  logic                        tx_busy_i,
  input  logic                        tx_done_i
);

  localparam int AW = $clog2(depth_g);
  localparam logic [AW:0] DepthLvl = depth_g[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_START,
    ST_WAIT_END
  } state_t;

  state_t                  state_q, state_d;
  logic [data_width_g-1:0] mem_q [depth_g];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             level_q, level_d;
  logic                    full_q, empty_q;
  logic [data_width_g-1:0] tx_data_q;
  logic                    push, pop, load;
  logic                    unused_done;

  // Completion is inferred from busy falling; done is observed only.
  assign unused_done = tx_done_i;

  assign push = wr_en_i && !full_q;
  assign pop  = (state_q == ST_LOAD);
  assign load = (state_q == ST_IDLE) && !empty_q && !tx_busy_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (load) state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_WAIT_START;
      ST_WAIT_START: if (tx_busy_i) state_d = ST_WAIT_END;
      ST_WAIT_END:   if (!tx_busy_i) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage has no reset so it maps onto block RAM; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
    if (!rst_asy_n_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_data_q <= '0;
    end else if (rst_syn_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      full_q  <= (level_d == DepthLvl);
      empty_q <= (level_d == '0);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (load) begin
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
    if (!rst_asy_n_i) begin
      overflow_q <= 1'b0;
    end else if (rst_syn_i) begin
      overflow_q <= 1'b0;
    end else if (wr_en_i && full_q) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;
  assign tx_data_o = tx_data_q;
  assign tx_en_o   = (state_q == ST_LOAD);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx busy model.
module tb_uart_tx_fifo;

  localparam int FRAME = 12;

  logic       clk_i = 1'b0;
  logic       rst_asy_n_i = 1'b0;
  logic       rst_syn_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       wr_en_i = 1'b0;
  logic       full_o, empty_o, overflow_o, tx_en_o;
  logic [4:0] level_o;
  logic [7:0] tx_data_o;
  logic       tx_busy_i, tx_done_i;

  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  int         max_level = 0;
  logic       force_busy = 1'b0;
  logic       prev_en = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.data_width_g(8), .depth_g(16)) dut (
    .clk_i(clk_i), .rst_asy_n_i(rst_asy_n_i), .rst_syn_i(rst_syn_i),
    .wr_data_i(wr_data_i), .wr_en_i(wr_en_i), .full_o(full_o), .empty_o(empty_o),
    .level_o(level_o), .overflow_o(overflow_o), .tx_data_o(tx_data_o),
    .tx_en_o(tx_en_o), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i)
  );

  always #5 clk_i = ~clk_i;

  // uart_tx stand-in: busy for FRAME cycles after each load strobe.
  assign tx_busy_i = force_busy || (busy_cnt != 0);
  assign tx_done_i = (busy_cnt == 1);

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (tx_en_o && busy_cnt == 0) busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every load strobe is compared against the scoreboard head.
  always @(negedge clk_i) begin
    if (int'(level_o) > max_level) max_level = int'(level_o);
    if (tx_en_o) begin
      pulses++;
      check("pulse_width", {31'd0, prev_en}, 0);
      check("pulse_while_idle", {31'd0, tx_busy_i}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data_o}, {24'd0, e});
        $display("[TB] cycle %0d tx_en data %02h expected %02h", cyc, tx_data_o, e);
      end
    end
    prev_en = tx_en_o;
  end

  task automatic wait_drain();
    int n = 0;
    while (!(exp_q.size() == 0 && empty_o && !tx_busy_i) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", {31'd0, n < 3000}, 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(posedge clk_i); #1;
    wr_en_i = 1'b1;
    wr_data_i = d;
  endtask

  task automatic write_end();
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [4];
    int c0, p0, sent, guard;
    burst[0] = 8'hAA; burst[1] = 8'hCC; burst[2] = 8'h55; burst[3] = 8'h33;

    repeat (3) @(posedge clk_i);
    #1 rst_asy_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_empty", {31'd0, empty_o}, 1);
    check("rst_full", {31'd0, full_o}, 0);
    check("rst_level", {27'd0, level_o}, 0);
    check("rst_tx_en", {31'd0, tx_en_o}, 0);
    check("rst_tx_data", {24'd0, tx_data_o}, 0);
    check("rst_overflow", {31'd0, overflow_o}, 0);

    // Single byte: strobe two cycles after the write.
    write_byte(8'hAA);
    c0 = cyc;
    exp_q.push_back(8'hAA);
    write_end();
    @(negedge clk_i);
    check("single_empty_fall", {31'd0, empty_o}, 0);
    check("single_level", {27'd0, level_o}, 1);
    @(negedge clk_i);
    check("single_latency_cyc", cyc - c0, 2);
    check("single_tx_en", {31'd0, tx_en_o}, 1);
    wait_drain();
    check("single_empty_back", {31'd0, empty_o}, 1);

    // Burst of four.
    p0 = pulses;
    foreach (burst[i]) begin
      write_byte(burst[i]);
      exp_q.push_back(burst[i]);
    end
    write_end();
    wait_drain();
    check("burst_pulses", pulses - p0, 4);

    // Fill with transmitter held busy; 17th word is dropped.
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      write_byte(i[7:0]);
      if (i < 16) exp_q.push_back(i[7:0]);
      if (i == 15) begin
        @(negedge clk_i);
        check("fill15_level", {27'd0, level_o}, 15);
        check("fill15_full", {31'd0, full_o}, 0);
      end
      if (i == 16) begin
        @(negedge clk_i);
        check("fill16_level", {27'd0, level_o}, 16);
        check("fill16_full", {31'd0, full_o}, 1);
      end
    end
    write_end();
    @(negedge clk_i);
    check("overflow_level", {27'd0, level_o}, 16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("overflow_flag", {31'd0, overflow_o}, 1);
`else
    check("overflow_flag", {31'd0, overflow_o}, 0);
`endif
    @(posedge clk_i); #1 force_busy = 1'b0;
    wait_drain();
    check("fill_drained_level", {27'd0, level_o}, 0);

    // Wrap-around with free-running transmitter.
    max_level = 0;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 5000) begin
      @(posedge clk_i); #1;
      if (!full_o) begin
        wr_en_i = 1'b1;
        wr_data_i = 8'h80 + sent[7:0];
        exp_q.push_back(8'h80 + sent[7:0]);
        sent++;
      end else begin
        wr_en_i = 1'b0;
      end
      guard++;
    end
    write_end();
    check("wrap_sent", sent, 40);
    wait_drain();
    check("wrap_max_level", {31'd0, max_level <= 16}, 1);

    // Write during the LOAD cycle with three words queued.
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_byte(8'h20 + i[7:0]);
      exp_q.push_back(8'h20 + i[7:0]);
    end
    write_end();
    @(negedge clk_i);
    check("simul_pre_level", {27'd0, level_o}, 3);
    @(posedge clk_i); #1 force_busy = 1'b0;
    write_byte(8'h23);
    exp_q.push_back(8'h23);
    @(negedge clk_i);
    check("simul_in_load", {31'd0, tx_en_o}, 1);
    write_end();
    @(negedge clk_i);
    check("simul_level", {27'd0, level_o}, 3);
    wait_drain();

    // Synchronous clear discards queued words.
    force_busy = 1'b1;
    write_byte(8'h41);
    write_byte(8'h42);
    write_end();
    rst_syn_i = 1'b1;
    @(posedge clk_i); #1 rst_syn_i = 1'b0;
    @(negedge clk_i);
    check("syn_clr_level", {27'd0, level_o}, 0);
    check("syn_clr_empty", {31'd0, empty_o}, 1);
    @(posedge clk_i); #1 force_busy = 1'b0;
    repeat (10) @(negedge clk_i);

    // Async reset while in WAIT_END with five words queued.
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_byte(8'h60 + i[7:0]);
      exp_q.push_back(8'h60 + i[7:0]);
    end
    write_end();
    @(posedge clk_i); #1 force_busy = 1'b0;
    repeat (4) @(negedge clk_i);
    check("midframe_level", {27'd0, level_o}, 5);
    #2 rst_asy_n_i = 1'b0;
    #1;
    check("arst_empty", {31'd0, empty_o}, 1);
    check("arst_level", {27'd0, level_o}, 0);
    check("arst_tx_en", {31'd0, tx_en_o}, 0);
    check("arst_tx_data", {24'd0, tx_data_o}, 0);
    exp_q.delete();
    @(posedge clk_i); #1 rst_asy_n_i = 1'b1;
    p0 = pulses;
    repeat (40) @(negedge clk_i);
    check("arst_no_pulses", pulses - p0, 0);
    write_byte(8'h77);
    exp_q.push_back(8'h77);
    write_end();
    wait_drain();
    check("final_pulse", pulses - p0, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
